// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment patterns, queue entry type and decoder
package seg7_pkg;

  // Active-low segment patterns, bit0=a ... bit6=g
  localparam logic [6:0] SEG_0     = ~7'h3F;
  localparam logic [6:0] SEG_1     = ~7'h06;
  localparam logic [6:0] SEG_2     = ~7'h5B;
  localparam logic [6:0] SEG_3     = ~7'h4F;
  localparam logic [6:0] SEG_4     = ~7'h66;
  localparam logic [6:0] SEG_5     = ~7'h6D;
  localparam logic [6:0] SEG_6     = ~7'h7D;
  localparam logic [6:0] SEG_7     = ~7'h07;
  localparam logic [6:0] SEG_8     = ~7'h7F;
  localparam logic [6:0] SEG_9     = ~7'h6F;
  localparam logic [6:0] SEG_A     = ~7'h77;
  localparam logic [6:0] SEG_B     = ~7'h7C;
  localparam logic [6:0] SEG_C     = ~7'h39;
  localparam logic [6:0] SEG_D     = ~7'h5E;
  localparam logic [6:0] SEG_E     = ~7'h79;
  localparam logic [6:0] SEG_F     = ~7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic       err;
    logic [3:0] digit;
  } seg7_entry_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] digit;
  } seg7_dec_t;

  function automatic seg7_dec_t seg7_decode(input logic [6:0] seg);
    seg7_dec_t r;
    r.valid = 1'b1;
    r.digit = 4'h0;
    case (seg)
      SEG_0:   r.digit = 4'h0;
      SEG_1:   r.digit = 4'h1;
      SEG_2:   r.digit = 4'h2;
      SEG_3:   r.digit = 4'h3;
      SEG_4:   r.digit = 4'h4;
      SEG_5:   r.digit = 4'h5;
      SEG_6:   r.digit = 4'h6;
      SEG_7:   r.digit = 4'h7;
      SEG_8:   r.digit = 4'h8;
      SEG_9:   r.digit = 4'h9;
      SEG_A:   r.digit = 4'hA;
      SEG_B:   r.digit = 4'hB;
      SEG_C:   r.digit = 4'hC;
      SEG_D:   r.digit = 4'hD;
      SEG_E:   r.digit = 4'hE;
      SEG_F:   r.digit = 4'hF;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_capture_fifo.sv
// rtl/seg7_capture_fifo.sv - first-word-fall-through queue of decoded entries
module seg7_capture_fifo
  import seg7_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  seg7_entry_t                push_data,
  input  logic                       pop,
  output seg7_entry_t                head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  seg7_entry_t   mem_q [DEPTH];
  seg7_entry_t   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == LW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign head    = mem_q[rd_ptr_q];
  // A pop on the same edge frees the slot, so a full queue still accepts
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // Next-state for storage, pointers and count; clr overrides any push/pop
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + LW'(1);
        2'b01:   cnt_d = cnt_q - LW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Queue state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - settle, decode and queue patterns seen on a 7-segment bus
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int STABLE = 4,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [6:0]             seg_in,
  input  logic                   clr,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [3:0]             out_digit,
  output logic                   out_err,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int             CW      = $clog2(STABLE) + 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE - 1);

  logic [6:0]    last_seg_q, last_seg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic          overflow_q, overflow_d;
  logic          commit;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  seg7_dec_t     dec;
  seg7_entry_t   push_data;
  seg7_entry_t   head;

  // Settle tracker: restart on any change, commit once after STABLE quiet edges
  always_comb begin
    last_seg_d = last_seg_q;
    cnt_d      = cnt_q;
    armed_d    = armed_q;
    commit     = 1'b0;
    if (seg_in != last_seg_q) begin
      last_seg_d = seg_in;
      cnt_d      = '0;
      armed_d    = 1'b1;
    end else if (armed_q) begin
      if (cnt_q == CNT_MAX) begin
        commit  = 1'b1;
        armed_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign dec             = seg7_decode(last_seg_q);
  assign push            = commit && (last_seg_q != SEG_BLANK);
  assign push_data.err   = !dec.valid;
  assign push_data.digit = dec.valid ? dec.digit : 4'h0;
  assign pop             = out_valid && out_ready;

  // Sticky overflow: set on a dropped push, cleared by clr
  always_comb begin
    overflow_d = overflow_q;
    if (clr) begin
      overflow_d = 1'b0;
    end else if (push && full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  // Tracker and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_seg_q <= SEG_BLANK;
      cnt_q      <= '0;
      armed_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      last_seg_q <= last_seg_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      overflow_q <= overflow_d;
    end
  end

  seg7_capture_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  assign out_valid = !empty;
  assign out_err   = !empty && head.err;
  assign out_digit = (!empty && !head.err) ? head.digit : 4'h0;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_seg7_capture.sv
// tb/tb_seg7_capture.sv - directed self-checking bench for seg7_capture
module tb_seg7_capture;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg_in;
  logic       clr;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_digit;
  logic       out_err;
  logic       overflow;
  logic [2:0] level;

  int vectors;
  int miscompares;

  seg7_capture #(
    .STABLE(4),
    .DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .seg_in   (seg_in),
    .clr      (clr),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_digit(out_digit),
    .out_err  (out_err),
    .overflow (overflow),
    .level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic [6:0] pat, input int n);
    seg_in = pat;
    tick(n);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    seg_in = 7'h7F;
    clr = 1'b0;
    out_ready = 1'b0;
    tick(2);
    vectors++;
    if ({out_valid, out_digit, out_err, overflow, level} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b d=%h e=%b o=%b l=%0d want all 0",
               out_valid, out_digit, out_err, overflow, level);
    end
    #3 rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_single();
    seg_in = ~7'h5B;
    tick(4);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_early: out_valid=%b want 0 before edge k+4", out_valid);
    end
    tick(1);
    vectors++;
    if (out_valid !== 1'b1 || out_digit !== 4'h2 || out_err !== 1'b0 || level !== 3'd1) begin
      miscompares++;
      $display("FAIL single_capture: v=%b d=%h e=%b l=%0d want v=1 d=2 e=0 l=1",
               out_valid, out_digit, out_err, level);
    end
    tick(5);
    vectors++;
    if (level !== 3'd1) begin
      miscompares++;
      $display("FAIL single_once: level=%0d want 1", level);
    end
    pop_one();
    vectors++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      miscompares++;
      $display("FAIL single_pop: v=%b l=%0d want v=0 l=0", out_valid, level);
    end
  endtask

  task automatic test_glitch();
    hold(~7'h06, 2);
    hold(~7'h4F, 8);
    vectors++;
    if (level !== 3'd1 || out_digit !== 4'h3 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch: l=%0d d=%h e=%b want l=1 d=3 e=0", level, out_digit, out_err);
    end
    pop_one();
  endtask

  task automatic test_blank();
    hold(~7'h3F, 6);
    hold(7'h7F, 6);
    hold(~7'h3F, 6);
    vectors++;
    if (level !== 3'd2 || out_digit !== 4'h0 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL blank_level: l=%0d d=%h e=%b want l=2 d=0 e=0", level, out_digit, out_err);
    end
    pop_one();
    vectors++;
    if (level !== 3'd1 || out_valid !== 1'b1 || out_digit !== 4'h0) begin
      miscompares++;
      $display("FAIL blank_second: l=%0d v=%b d=%h want l=1 v=1 d=0", level, out_valid, out_digit);
    end
    pop_one();
  endtask

  task automatic test_err();
    hold(7'h01, 6);
    vectors++;
    if (out_valid !== 1'b1 || out_err !== 1'b1 || out_digit !== 4'h0 || level !== 3'd1) begin
      miscompares++;
      $display("FAIL err_entry: v=%b e=%b d=%h l=%0d want v=1 e=1 d=0 l=1",
               out_valid, out_err, out_digit, level);
    end
    pop_one();
  endtask

  task automatic test_overflow();
    logic [6:0] pats [5];
    logic [3:0] exp;
    pats[0] = ~7'h06;
    pats[1] = ~7'h5B;
    pats[2] = ~7'h4F;
    pats[3] = ~7'h66;
    pats[4] = ~7'h6D;
    for (int i = 0; i < 5; i++) hold(pats[i], 6);
    vectors++;
    if (level !== 3'd4 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_full: l=%0d o=%b want l=4 o=1", level, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      exp = 4'(i + 1);
      vectors++;
      if (out_valid !== 1'b1 || out_digit !== exp) begin
        miscompares++;
        $display("FAIL ovf_pop%0d: v=%b d=%h want v=1 d=%h", i, out_valid, out_digit, exp);
      end
      pop_one();
    end
    vectors++;
    if (level !== 3'd0 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_sticky: l=%0d o=%b want l=0 o=1", level, overflow);
    end
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    vectors++;
    if (level !== 3'd0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clr: l=%0d o=%b want l=0 o=0", level, overflow);
    end
  endtask

  task automatic test_back_to_back();
    hold(~7'h7D, 6);
    hold(~7'h07, 6);
    hold(~7'h7F, 6);
    hold(~7'h6F, 6);
    vectors++;
    if (level !== 3'd4 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_fill: l=%0d o=%b want l=4 o=0", level, overflow);
    end
    seg_in = ~7'h77;
    tick(4);
    pop_one();
    vectors++;
    if (level !== 3'd4 || overflow !== 1'b0 || out_digit !== 4'h7) begin
      miscompares++;
      $display("FAIL b2b_pushpop: l=%0d o=%b d=%h want l=4 o=0 d=7", level, overflow, out_digit);
    end
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    vectors++;
    if (level !== 3'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_clr: l=%0d v=%b want l=0 v=0", level, out_valid);
    end
  endtask

  task automatic test_clr_commit();
    seg_in = ~7'h71;
    tick(4);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(4);
    vectors++;
    if (level !== 3'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_commit: l=%0d v=%b want l=0 v=0", level, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    hold(~7'h39, 6);
    vectors++;
    if (level !== 3'd1 || out_digit !== 4'hC) begin
      miscompares++;
      $display("FAIL rmid_setup: l=%0d d=%h want l=1 d=C", level, out_digit);
    end
    hold(~7'h79, 2);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, out_digit, out_err, overflow, level} !== 10'b0) begin
      miscompares++;
      $display("FAIL rmid_async: v=%b d=%h e=%b o=%b l=%0d want all 0",
               out_valid, out_digit, out_err, overflow, level);
    end
    seg_in = 7'h7F;
    tick(1);
    #2 rst_n = 1'b1;
    tick(8);
    vectors++;
    if (level !== 3'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_nocommit: l=%0d v=%b want l=0 v=0", level, out_valid);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single();
    test_glitch();
    test_blank();
    test_err();
    test_overflow();
    test_back_to_back();
    test_clr_commit();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
